// File: rtl/video_timing_probe_if.sv
// Video-side inputs and 16-bit register window of the timing probe.
// The generator/CPU side uses the master modport, the probe uses slave.
interface video_timing_probe_if;
    logic        ce_pix;
    logic        hsync;
    logic        hblank;
    logic        vsync;
    logic        vblank;
    logic [2:0]  address;
    logic        clear;
    logic [15:0] dout;
    logic        valid;
    logic        frame_pulse;

    modport master (
        output ce_pix,
        output hsync,
        output hblank,
        output vsync,
        output vblank,
        output address,
        output clear,
        input  dout,
        input  valid,
        input  frame_pulse
    );

    modport slave (
        input  ce_pix,
        input  hsync,
        input  hblank,
        input  vsync,
        input  vblank,
        input  address,
        input  clear,
        output dout,
        output valid,
        output frame_pulse
    );
endinterface

// File: rtl/video_timing_probe.sv
// Passive video timing probe. Counts pixels, active pixels, lines and clk
// cycles of the incoming CRTC timing, and once per frame publishes a coherent
// snapshot (line length, active width, total/active lines, frame period, frame
// number) through an 8-entry, 16-bit read-only register window.
module video_timing_probe #(
    parameter int CNT_W = 12,
    parameter int CLK_W = 24
) (
    input logic                 clk,
    input logic                 reset,
    video_timing_probe_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [CLK_W-1:0] clk_inc(input logic [CLK_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    state_t state;

    logic prev_hsync;
    logic prev_vsync;
    logic hsync_rise;
    logic vsync_rise;
    logic act_pix;

    // Working counters
    logic [CNT_W-1:0] pix;
    logic [CNT_W-1:0] act;
    logic [CNT_W-1:0] lines;
    logic [CNT_W-1:0] alines;
    logic [CLK_W-1:0] clks;
    logic [CNT_W-1:0] line_len;
    logic [CNT_W-1:0] hmax_act;

    // Values as they stand once a line closing in this cycle is accounted for
    logic [CNT_W-1:0] line_len_closed;
    logic [CNT_W-1:0] hmax_closed;
    logic [CNT_W-1:0] lines_closed;
    logic [CNT_W-1:0] alines_closed;
    logic [CLK_W-1:0] clks_next;
    logic             sat_event;

    // Published snapshot and status
    logic [CNT_W-1:0] h_total;
    logic [CNT_W-1:0] h_active;
    logic [CNT_W-1:0] v_total;
    logic [CNT_W-1:0] v_active;
    logic [CLK_W-1:0] frame_clks;
    logic [15:0]      frame_count;
    logic             changed;
    logic             error;
    logic             valid;
    logic             frame_pulse;
    logic [15:0]      dout;

    assign hsync_rise = bus.hsync & ~prev_hsync;
    assign vsync_rise = bus.vsync & ~prev_vsync;
    assign act_pix    = bus.ce_pix & ~bus.hblank & ~bus.vblank;
    assign clks_next  = clk_inc(clks);

    // Close the current line first when hsync rises, so a coincident vsync
    // sees that line as part of the frame it ends.
    always_comb begin
        line_len_closed = line_len;
        hmax_closed     = hmax_act;
        lines_closed    = lines;
        alines_closed   = alines;
        if (hsync_rise) begin
            line_len_closed = pix;
            lines_closed    = cnt_inc(lines);
            if (act != '0) begin
                alines_closed = cnt_inc(alines);
                hmax_closed   = act;
            end
        end
    end

    // Any counter that would step past all-ones this cycle.
    always_comb begin
        sat_event = 1'b0;
        if (!hsync_rise && bus.ce_pix && (pix == '1))
            sat_event = 1'b1;
        if (!hsync_rise && act_pix && (act == '1))
            sat_event = 1'b1;
        if (hsync_rise && (lines == '1))
            sat_event = 1'b1;
        if (hsync_rise && (act != '0) && (alines == '1))
            sat_event = 1'b1;
        if (clks == '1)
            sat_event = 1'b1;
    end

    // Edge-detect history for the sync inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_hsync <= 1'b0;
            prev_vsync <= 1'b0;
        end else begin
            prev_hsync <= bus.hsync;
            prev_vsync <= bus.vsync;
        end
    end

    // Per-line pixel counters; a pixel on the hsync-rise cycle opens the new line.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix <= '0;
            act <= '0;
        end else if (hsync_rise) begin
            pix <= CNT_W'(bus.ce_pix);
            act <= CNT_W'(act_pix);
        end else begin
            if (bus.ce_pix)
                pix <= cnt_inc(pix);
            if (act_pix)
                act <= cnt_inc(act);
        end
    end

    // Per-frame counters; restart on vsync rise, full wipe when arming from IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            lines    <= '0;
            alines   <= '0;
            clks     <= '0;
            line_len <= '0;
            hmax_act <= '0;
        end else if (vsync_rise) begin
            lines  <= '0;
            alines <= '0;
            clks   <= '0;
            if (state == IDLE) begin
                line_len <= '0;
                hmax_act <= '0;
            end else begin
                line_len <= line_len_closed;
                hmax_act <= hmax_closed;
            end
        end else begin
            lines    <= lines_closed;
            alines   <= alines_closed;
            clks     <= clks_next;
            line_len <= line_len_closed;
            hmax_act <= hmax_closed;
        end
    end

    // Sticky saturation flag; a new saturation beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset)
            error <= 1'b0;
        else if (sat_event)
            error <= 1'b1;
        else if (bus.clear)
            error <= 1'b0;
    end

    // Frame state machine: arm on the first vsync, then publish a snapshot on every later one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            valid       <= 1'b0;
            frame_pulse <= 1'b0;
            changed     <= 1'b0;
            h_total     <= '0;
            h_active    <= '0;
            v_total     <= '0;
            v_active    <= '0;
            frame_clks  <= '0;
            frame_count <= '0;
        end else begin
            frame_pulse <= 1'b0;
            if (bus.clear)
                changed <= 1'b0;
            if (vsync_rise) begin
                case (state)
                    IDLE: begin
                        state <= ARM;
                    end
                    ARM, RUN: begin
                        h_total     <= line_len_closed;
                        h_active    <= hmax_closed;
                        v_total     <= lines_closed;
                        v_active    <= alines_closed;
                        frame_clks  <= clks_next;
                        frame_count <= frame_count + 16'd1;
                        frame_pulse <= 1'b1;
                        valid       <= 1'b1;
                        if ((state == RUN) &&
                            ((line_len_closed != h_total) || (lines_closed != v_total)))
                            changed <= 1'b1;
                        state <= RUN;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Register window read mux.
    always_comb begin
        dout = '0;
        case (bus.address)
            3'd0:    dout = 16'(h_total);
            3'd1:    dout = 16'(h_active);
            3'd2:    dout = 16'(v_total);
            3'd3:    dout = 16'(v_active);
            3'd4:    dout = frame_clks[15:0];
            3'd5:    dout = 16'(frame_clks >> 16);
            3'd6:    dout = frame_count;
            3'd7:    dout = {13'b0, error, changed, valid};
            default: dout = '0;
        endcase
    end

    assign bus.dout        = dout;
    assign bus.valid       = valid;
    assign bus.frame_pulse = frame_pulse;

endmodule

// File: tb/tb_video_timing_probe.sv
// Bench for video_timing_probe: a synthetic CRTC (8 pixels/line, ce_pix every
// other clk) drives the probe; expected register values per checkpoint live in
// a vector table, plus hand-built sequences for saturation, coincident syncs,
// frame-period carry into the high word and mid-frame reset.
`timescale 1ns/1ps
module tb_video_timing_probe;

    localparam int CNT_W = 12;
    localparam int CLK_W = 24;
    localparam int LONG_PIXELS = 32800;

    typedef struct {
        int          phase;
        logic [2:0]  addr;
        logic [15:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   pulse_count = 0;
    vec_t vecs[$];

    video_timing_probe_if bus ();

    video_timing_probe #(
        .CNT_W(CNT_W),
        .CLK_W(CLK_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #50 clk = ~clk;

    // Count published snapshots.
    always @(negedge clk) begin
        if (bus.frame_pulse === 1'b1)
            pulse_count++;
    end

    task automatic add_vec(input int phase, input logic [2:0] addr, input logic [15:0] exp);
        vec_t v;
        v.phase = phase;
        v.addr  = addr;
        v.exp   = exp;
        vecs.push_back(v);
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_phase(input int phase);
        foreach (vecs[i]) begin
            if (vecs[i].phase == phase) begin
                bus.address = vecs[i].addr;
                #1;
                check_output($sformatf("ph%0d_reg%0d", phase, vecs[i].addr),
                             32'(bus.dout), 32'(vecs[i].exp));
            end
        end
    endtask

    task automatic apply_stimulus(input logic ce, input logic hs, input logic hb,
                                  input logic vs, input logic vb, input logic clr,
                                  input logic rst);
        @(negedge clk);
        bus.ce_pix = ce;
        bus.hsync  = hs;
        bus.hblank = hb;
        bus.vsync  = vs;
        bus.vblank = vb;
        bus.clear  = clr;
        reset      = rst;
    endtask

    task automatic pixel(input logic hs, input logic hb, input logic vs, input logic vb,
                         input logic clr);
        apply_stimulus(1'b1, hs, hb, vs, vb, clr, 1'b0);
        apply_stimulus(1'b0, hs, hb, vs, vb, 1'b0, 1'b0);
    endtask

    // clr_mode 1: clear on line 0 pixel 0; 2: clear on the vsync rise clk.
    task automatic gen_lines(input int first, input int last, input int nlines,
                             input int vs_px, input int clr_mode);
        logic vs;
        logic clr;
        for (int l = first; l <= last; l++) begin
            for (int p = 0; p < 8; p++) begin
                vs  = (l == nlines - 1) && (p >= vs_px);
                clr = ((clr_mode == 1) && (l == 0) && (p == 0)) ||
                      ((clr_mode == 2) && (l == nlines - 1) && (p == vs_px));
                pixel(p == 7, p >= 6, vs, l >= nlines - 2, clr);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 8; a++) begin
            add_vec(0, 3'(a), 16'd0);
            add_vec(11, 3'(a), 16'd0);
        end
        add_vec(1, 3'd7, 16'd0);
        add_vec(2, 3'd0, 16'd8);  add_vec(2, 3'd1, 16'd6);  add_vec(2, 3'd2, 16'd5);
        add_vec(2, 3'd3, 16'd3);  add_vec(2, 3'd4, 16'd80); add_vec(2, 3'd5, 16'd0);
        add_vec(2, 3'd6, 16'd1);  add_vec(2, 3'd7, 16'd1);
        add_vec(3, 3'd0, 16'd8);  add_vec(3, 3'd2, 16'd5);  add_vec(3, 3'd4, 16'd80);
        add_vec(3, 3'd6, 16'd2);  add_vec(3, 3'd7, 16'd1);
        add_vec(4, 3'd0, 16'd8);  add_vec(4, 3'd1, 16'd6);  add_vec(4, 3'd2, 16'd6);
        add_vec(4, 3'd3, 16'd4);  add_vec(4, 3'd4, 16'd96); add_vec(4, 3'd5, 16'd0);
        add_vec(4, 3'd6, 16'd3);  add_vec(4, 3'd7, 16'd3);
        add_vec(5, 3'd7, 16'd1);
        add_vec(6, 3'd2, 16'd5);  add_vec(6, 3'd3, 16'd3);  add_vec(6, 3'd4, 16'd80);
        add_vec(6, 3'd6, 16'd4);  add_vec(6, 3'd7, 16'd3);
        add_vec(7, 3'd0, 16'd8);  add_vec(7, 3'd1, 16'd6);  add_vec(7, 3'd2, 16'd6);
        add_vec(7, 3'd3, 16'd3);  add_vec(7, 3'd4, 16'd94); add_vec(7, 3'd6, 16'd5);
        add_vec(8, 3'd0, 16'd8);  add_vec(8, 3'd2, 16'd5);  add_vec(8, 3'd3, 16'd3);
        add_vec(8, 3'd4, 16'd80); add_vec(8, 3'd6, 16'd6);
        add_vec(9, 3'd4, 16'h0044); add_vec(9, 3'd5, 16'h0001);
        add_vec(9, 3'd0, 16'd4095); add_vec(9, 3'd1, 16'd4095); add_vec(9, 3'd2, 16'd1);
        add_vec(9, 3'd3, 16'd1);  add_vec(9, 3'd6, 16'd7);  add_vec(9, 3'd7, 16'd7);
        add_vec(10, 3'd7, 16'd1);
        add_vec(12, 3'd6, 16'd0); add_vec(12, 3'd7, 16'd0);
        add_vec(13, 3'd0, 16'd8);  add_vec(13, 3'd1, 16'd6);  add_vec(13, 3'd2, 16'd5);
        add_vec(13, 3'd3, 16'd3);  add_vec(13, 3'd4, 16'd80); add_vec(13, 3'd5, 16'd0);
        add_vec(13, 3'd6, 16'd1);  add_vec(13, 3'd7, 16'd1);

        bus.ce_pix  = 1'b0;
        bus.hsync   = 1'b0;
        bus.hblank  = 1'b0;
        bus.vsync   = 1'b0;
        bus.vblank  = 1'b0;
        bus.clear   = 1'b0;
        bus.address = 3'd0;

        repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_phase(0);
        check_output("reset_valid", 32'(bus.valid), 32'd0);
        check_output("reset_pulse", 32'(bus.frame_pulse), 32'd0);

        // Arm, then two measured 5-line frames
        gen_lines(0, 4, 5, 0, 0);
        check_phase(1);
        check_output("pulses_after_arm", 32'(pulse_count), 32'd0);
        gen_lines(0, 4, 5, 0, 0);
        check_phase(2);
        check_output("pulses_frame2", 32'(pulse_count), 32'd1);
        gen_lines(0, 4, 5, 0, 0);
        check_phase(3);
        check_output("pulses_frame3", 32'(pulse_count), 32'd2);

        // Geometry change, clear, then clear racing a set event
        gen_lines(0, 5, 6, 0, 0);
        check_phase(4);
        gen_lines(0, 0, 5, 0, 1);
        check_phase(5);
        gen_lines(1, 4, 5, 0, 2);
        check_phase(6);

        // hsync and vsync rising together
        gen_lines(0, 4, 5, 7, 0);
        check_phase(7);
        gen_lines(0, 4, 5, 7, 0);
        check_phase(8);
        check_output("pulses_coincident", 32'(pulse_count), 32'd6);

        // Long line: pixel counters saturate, frame period carries into high word
        repeat (LONG_PIXELS) pixel(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pixel(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_output("long_frame_pulse", 32'(bus.frame_pulse), 32'd1);
        check_phase(9);
        pixel(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_phase(10);

        // Mid-frame reset while running
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_phase(11);
        check_output("midreset_valid", 32'(bus.valid), 32'd0);
        gen_lines(0, 4, 5, 0, 0);
        check_phase(12);
        check_output("rearm_valid", 32'(bus.valid), 32'd0);
        gen_lines(0, 4, 5, 0, 0);
        check_phase(13);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/video_timing_probe.md
Name: video_timing_probe

Overview:
- Passive monitor on the video outputs of the CPU test core: ce_pix, hsync, hblank, vsync and vblank from the CRTC path.
- Measures line and frame geometry in pixel, line and clk units.
- Publishes one atomic snapshot per frame through a 16-bit read-only register window, so the 68000 can report the real output timing alongside its latency tick counter.

Parameters:
- CNT_W, 12, width of the pixel and line counters; matches the CRTC hcnt/vcnt width.
- CLK_W, 24, width of the frame-period counter in clk cycles.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ce_pix  in  1  pixel clock enable.
- hsync  in  1  horizontal sync, active-high.
- hblank  in  1  horizontal blank, active-high.
- vsync  in  1  vertical sync, active-high.
- vblank  in  1  vertical blank, active-high.
- address  in  3  register select.
- clear  in  1  one-cycle strobe; clears the sticky status bits.
- dout  out  16  register read data, combinational from address.
- valid  out  1  high once the first complete frame has been measured.
- frame_pulse  out  1  one-clk strobe when a new snapshot is published.

Behaviour:
- Reset: every counter, shadow register, sticky bit, valid and frame_pulse goes to 0; state goes to IDLE. Reset mid-frame discards all partial counts.
- Edge detect: all inputs are registered once as prev_*. A rise occurs in cycle N when the input is 1 at N and prev was 0 at N-1.
- Working counters:
  - pix: ce_pix cycles since the last hsync rise.
  - act: ce_pix cycles with hblank=0 and vblank=0 since the last hsync rise.
  - lines: hsync rises since the last vsync rise.
  - alines: lines with act>0 at their closing hsync rise.
  - clks: clk cycles since the last vsync rise.
  - hmax_act: act value of the most recent line with act>0.
- hsync rise: line_len<=pix; alines++ if act>0 (and hmax_act<=act); lines++; pix and act restart. The restart value is 1 if ce_pix is high that cycle (counted in the new line), else 0.
- vsync rise: frame closes. If an hsync rise occurs in the same cycle, that line is counted first and belongs to the closing frame.
- Saturation: all counters saturate at all-ones. Any saturation sets sticky error.
- State machine:
  - IDLE -> ARM on the first vsync rise. Counters are cleared; no snapshot.
  - ARM -> RUN on the next vsync rise. First snapshot published; valid<=1.
  - RUN stays in RUN. Every vsync rise publishes a snapshot.
  - Only reset leaves RUN.
- Snapshot contents:
  - h_total<=line_len; h_active<=hmax_act; v_total<=lines (including a coincident line); v_active<=alines; frame_clks<=clks+1; frame_count++ (16-bit, wraps).
  - Snapshot regs and frame_pulse update at N+1 for an edge detected at N. dout reflects them at N+1.
- changed (sticky):
  - Set when a RUN-state snapshot's h_total or v_total differs from the previous snapshot.
  - Never set by the first snapshot.
- clear zeroes changed and error. If a set event occurs in the same cycle as clear, set wins.
- Register map (dout); unused bits read 0:
  - 0: h_total
  - 1: h_active
  - 2: v_total
  - 3: v_active
  - 4: frame_clks[15:0]
  - 5: frame_clks[CLK_W-1:16]
  - 6: frame_count
  - 7: {13'b0, error, changed, valid}
- Coherency: addresses 4 and 5 come from the same snapshot. The whole snapshot changes in a single cycle, so no torn reads.
- hblank/vblank are only sampled with ce_pix. hsync, vsync and clks are evaluated every clk.

Test Plan:
- Synthetic generator with ce_pix every other clk, 8 pixels/line (hblank on pixels 6-7, hsync on pixel 7), 5 lines/frame (vblank lines 3-4, vsync line 4), run 3 frames:
  - valid rises at the 2nd vsync rise.
  - Registers read h_total=8, h_active=6, v_total=5, v_active=3, frame_clks=80, frame_count=1, then 2.
  - frame_pulse fires exactly once per frame after ARM.
- Change the generator to 6 lines/frame: next snapshot v_total=6, frame_clks=96, changed=1.
  - Pulse clear: changed=0.
  - Repeat with clear in the same cycle as the set event: changed=1.
- hsync and vsync rising in the same clk: v_total includes that line (5, not 4); next frame lines start at 0.
- Hold hsync low for 5000 ce_pix with CNT_W=12: h_total saturates at 4095, error=1, counters do not wrap.
- Assert reset for 1 clk mid-frame in RUN: all registers read 0, valid=0. Needs two more vsync rises before valid=1.
- Read addresses 4/5 on the frame_pulse cycle with frame_clks crossing 0xFFFF->0x10000 between frames: both halves come from the same snapshot.
